// File: rtl/irq_source_dispatcher_pkg.sv
// Shared types and constants for the interrupt source dispatcher.
// Holds the FSM encoding, source/ID widths and an ID-to-one-hot helper.
package irq_pkg;

   localparam int NUM_SRC = 7;
   localparam int ID_W    = 3;
   localparam logic [ID_W-1:0] ID_NONE = 3'd0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   // One-hot mask of the source named by a 1-based ID; ID_NONE gives an empty mask.
   function automatic logic [NUM_SRC-1:0] id_to_mask(input logic [ID_W-1:0] id);
      logic [NUM_SRC-1:0] m;
      m = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         m[i] = (id == ID_W'(i + 1));
      end
      return m;
   endfunction

endpackage

// File: rtl/irq_source_dispatcher_if.sv
// Dispatch handshake between the interrupt dispatcher (master) and the CPU trap stage (slave).
interface irq_source_dispatcher_if;
   import irq_pkg::*;

   logic            Irq_Valid;
   logic [ID_W-1:0] Irq_Id;
   logic            Irq_Ack;
   logic            Irq_Done;

   modport master (output Irq_Valid, output Irq_Id, input Irq_Ack, input Irq_Done);
   modport slave  (input Irq_Valid, input Irq_Id, output Irq_Ack, output Irq_Done);

endinterface

// File: rtl/irq_source_dispatcher_prio_enc.sv
// Fixed-priority encoder: returns 1-based index of the lowest set bit, 0 when empty.
module irq_prio_enc_7
   import irq_pkg::*;
(
   input  logic [NUM_SRC-1:0] vec,
   output logic [ID_W-1:0]    id
);

   // Lowest index wins, so source 1 has the highest priority.
   always_comb begin
      id = ID_NONE;
      casez (vec)
         7'b??????1: id = 3'd1;
         7'b?????10: id = 3'd2;
         7'b????100: id = 3'd3;
         7'b???1000: id = 3'd4;
         7'b??10000: id = 3'd5;
         7'b?100000: id = 3'd6;
         7'b1000000: id = 3'd7;
         default:    id = ID_NONE;
      endcase
   end

endmodule

// File: rtl/irq_source_dispatcher.sv
// Latches seven interrupt sources with per-source polarity and trigger type,
// then dispatches one at a time by fixed priority over a valid/ack/done handshake.
module irq_source_dispatcher
   import irq_pkg::*;
#(
   parameter logic [NUM_SRC-1:0] BubblesMask = 7'h00,
   parameter logic [NUM_SRC-1:0] EdgeMask    = 7'h7F
)(
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic [NUM_SRC-1:0]    Req,
   input  logic [NUM_SRC-1:0]    Enable,
   irq_source_dispatcher_if.master irq,
   output logic [NUM_SRC-1:0]    Pending,
   output logic                  Busy
);

   logic [NUM_SRC-1:0] real_req_s;
   logic [NUM_SRC-1:0] req_q_r;
   logic [NUM_SRC-1:0] pending_r;
   logic [NUM_SRC-1:0] pending_n_s;
   logic [NUM_SRC-1:0] candidate_s;
   logic [ID_W-1:0]    winner_id_s;
   logic [ID_W-1:0]    id_r;
   logic [ID_W-1:0]    id_n_s;
   state_e             state_r;
   state_e             state_n_s;
   logic               valid_r;
   logic               busy_r;
   logic               ack_take_s;
   logic               sel_live_s;

   assign real_req_s  = Req ^ BubblesMask;
   assign candidate_s = pending_r & Enable;
   assign ack_take_s  = (state_r == REQ) && irq.Irq_Ack;
   // The latched source is still eligible only while it is both pending and enabled.
   assign sel_live_s  = |(candidate_s & id_to_mask(id_r));

   irq_prio_enc_7 u_prio (
      .vec (candidate_s),
      .id  (winner_id_s)
   );

   // Pending update: edge sources set on a rise (set beats ack-clear), level sources follow the line.
   always_comb begin
      pending_n_s = pending_r;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (EdgeMask[i]) begin
            if (real_req_s[i] && !req_q_r[i]) begin
               pending_n_s[i] = 1'b1;
            end else if (ack_take_s && (id_r == ID_W'(i + 1))) begin
               pending_n_s[i] = 1'b0;
            end else begin
               pending_n_s[i] = pending_r[i];
            end
         end else begin
            pending_n_s[i] = real_req_s[i];
         end
      end
   end

   // Dispatch FSM next-state and latched ID.
   always_comb begin
      state_n_s = state_r;
      id_n_s    = id_r;
      case (state_r)
         IDLE: begin
            if (|candidate_s) begin
               state_n_s = REQ;
               id_n_s    = winner_id_s;
            end else begin
               state_n_s = IDLE;
               id_n_s    = ID_NONE;
            end
         end
         REQ: begin
            // Ack beats a simultaneous withdrawal; Done is ignored here.
            if (irq.Irq_Ack) begin
               state_n_s = SERVICE;
            end else if (!sel_live_s) begin
               state_n_s = IDLE;
               id_n_s    = ID_NONE;
            end else begin
               state_n_s = REQ;
            end
         end
         SERVICE: begin
            if (irq.Irq_Done) begin
               state_n_s = IDLE;
               id_n_s    = ID_NONE;
            end else begin
               state_n_s = SERVICE;
            end
         end
         default: begin
            state_n_s = IDLE;
            id_n_s    = ID_NONE;
         end
      endcase
   end

   // State, pending and registered outputs.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r   <= IDLE;
         id_r      <= ID_NONE;
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
         pending_r <= {NUM_SRC{1'b0}};
         req_q_r   <= {NUM_SRC{1'b0}};
      end else begin
         state_r   <= state_n_s;
         id_r      <= id_n_s;
         valid_r   <= (state_n_s == REQ);
         busy_r    <= (state_n_s == SERVICE);
         pending_r <= pending_n_s;
         req_q_r   <= real_req_s;
      end
   end

   assign irq.Irq_Valid = valid_r;
   assign irq.Irq_Id    = id_r;
   assign Pending       = pending_r;
   assign Busy          = busy_r;

endmodule

// File: tb/tb_irq_source_dispatcher.sv
// Directed scoreboard bench: dut0 uses default masks, dut1 has an active-low source 1 and a level source 4.
module tb_irq_source_dispatcher;
   import irq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] req0, en0, pend0, req1, en1, pend1;
   logic       busy0, busy1;

   irq_source_dispatcher_if if0 ();
   irq_source_dispatcher_if if1 ();

   irq_source_dispatcher dut0 (
      .Clock (clk), .Reset_n (rst_n), .Req (req0), .Enable (en0),
      .irq (if0), .Pending (pend0), .Busy (busy0)
   );

   irq_source_dispatcher #(.BubblesMask (7'h01), .EdgeMask (7'h77)) dut1 (
      .Clock (clk), .Reset_n (rst_n), .Req (req1), .Enable (en1),
      .irq (if1), .Pending (pend1), .Busy (busy1)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int unsigned dut;
      logic [11:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Observation word: {Valid, Busy, Id[2:0], Pending[6:0]}.
   function automatic logic [11:0] snap(input int unsigned d);
      if (d == 0) return {if0.Irq_Valid, busy0, if0.Irq_Id, pend0};
      else        return {if1.Irq_Valid, busy1, if1.Irq_Id, pend1};
   endfunction

   task automatic x(input string tag, input int unsigned d, input logic v, input logic b,
                    input logic [2:0] id, input logic [6:0] p);
      exp_t e;
      e.tag = tag; e.dut = d; e.exp = {v, b, id, p};
      sb.push_back(e);
   endtask

   task automatic check_queue();
      exp_t        e;
      logic [11:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = snap(e.dut);
         n_tests++;
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", e.tag, e.dut, obs, e.exp);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_queue();
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 7'h00; en0 = 7'h7F; if0.Irq_Ack = 1'b0; if0.Irq_Done = 1'b0;
      req1 = 7'h01; en1 = 7'h7F; if1.Irq_Ack = 1'b0; if1.Irq_Done = 1'b0;
      #2;
      x("rst0", 0, 0, 0, 3'd0, 7'h00); x("rst1", 1, 0, 0, 3'd0, 7'h00); check_queue();
      @(posedge clk); #1; rst_n = 1'b1;
      x("rel0", 0, 0, 0, 3'd0, 7'h00); x("rel1", 1, 0, 0, 3'd0, 7'h00); step();

      // Bring dut0 into SERVICE with Pending = 05, then reset asynchronously.
      req0 = 7'h05;                 x("pre_pend", 0, 0, 0, 3'd0, 7'h05); step();
      req0 = 7'h00;                 x("pre_req", 0, 1, 0, 3'd1, 7'h05); step();
      if0.Irq_Ack = 1'b1;           x("pre_ack", 0, 0, 1, 3'd1, 7'h04); step();
      if0.Irq_Ack = 1'b0; req0 = 7'h01;
                                    x("pre_svc", 0, 0, 1, 3'd1, 7'h05); step();
      req0 = 7'h00;
      rst_n = 1'b0; #1;
      x("async_rst", 0, 0, 0, 3'd0, 7'h00); check_queue();
      step();
      rst_n = 1'b1;                 x("rst_idle_a", 0, 0, 0, 3'd0, 7'h00); step();
                                    x("rst_idle_b", 0, 0, 0, 3'd0, 7'h00); step();

      // Single edge on source 3.
      req0 = 7'h04;                 x("se_pend", 0, 0, 0, 3'd0, 7'h04); step();
      req0 = 7'h00;                 x("se_valid", 0, 1, 0, 3'd3, 7'h04); step();
      if0.Irq_Ack = 1'b1;           x("se_ack", 0, 0, 1, 3'd3, 7'h00); step();
      if0.Irq_Ack = 1'b0;           x("se_hold", 0, 0, 1, 3'd3, 7'h00); step();
      if0.Irq_Done = 1'b1;          x("se_done", 0, 0, 0, 3'd0, 7'h00); step();
      if0.Irq_Done = 1'b0;

      // Ack and Done while IDLE are ignored.
      if0.Irq_Ack = 1'b1; if0.Irq_Done = 1'b1;
                                    x("idle_ackdone", 0, 0, 0, 3'd0, 7'h00); step();
      if0.Irq_Ack = 1'b0; if0.Irq_Done = 1'b0;

      // Priority: sources 2 and 5 together; Ack+Done in REQ acts as Ack.
      req0 = 7'h12;                 x("pr_pend", 0, 0, 0, 3'd0, 7'h12); step();
      req0 = 7'h00;                 x("pr_id2", 0, 1, 0, 3'd2, 7'h12); step();
      if0.Irq_Ack = 1'b1; if0.Irq_Done = 1'b1;
                                    x("pr_ackdone", 0, 0, 1, 3'd2, 7'h10); step();
      if0.Irq_Ack = 1'b0;           x("pr_done", 0, 0, 0, 3'd0, 7'h10); step();
      if0.Irq_Done = 1'b0;          x("pr_id5", 0, 1, 0, 3'd5, 7'h10); step();
      if0.Irq_Ack = 1'b1;           x("pr_ack5", 0, 0, 1, 3'd5, 7'h00); step();
      if0.Irq_Ack = 1'b0; if0.Irq_Done = 1'b1;
                                    x("pr_done5", 0, 0, 0, 3'd0, 7'h00); step();
      if0.Irq_Done = 1'b0;

      // New edge on the in-service source during the Ack cycle stays pending.
      req0 = 7'h04;                 x("ae_pend", 0, 0, 0, 3'd0, 7'h04); step();
      req0 = 7'h00;                 x("ae_valid", 0, 1, 0, 3'd3, 7'h04); step();
      if0.Irq_Ack = 1'b1; req0 = 7'h04;
                                    x("ae_setwins", 0, 0, 1, 3'd3, 7'h04); step();
      if0.Irq_Ack = 1'b0; req0 = 7'h00; if0.Irq_Done = 1'b1;
                                    x("ae_done", 0, 0, 0, 3'd0, 7'h04); step();
      if0.Irq_Done = 1'b0;          x("ae_again", 0, 1, 0, 3'd3, 7'h04); step();
      if0.Irq_Ack = 1'b1;           x("ae_ack2", 0, 0, 1, 3'd3, 7'h00); step();
      if0.Irq_Ack = 1'b0; if0.Irq_Done = 1'b1;
                                    x("ae_done2", 0, 0, 0, 3'd0, 7'h00); step();
      if0.Irq_Done = 1'b0;

      // Withdrawal: level source 4 drops before Ack.
      req1 = 7'h09;                 x("wd_pend", 1, 0, 0, 3'd0, 7'h08); step();
                                    x("wd_valid", 1, 1, 0, 3'd4, 7'h08); step();
      req1 = 7'h01;                 x("wd_drop", 1, 1, 0, 3'd4, 7'h00); step();
                                    x("wd_idle", 1, 0, 0, 3'd0, 7'h00); step();
                                    x("wd_nosvc", 1, 0, 0, 3'd0, 7'h00); step();

      // Active-low source 1 and Enable gating.
      req1 = 7'h00;                 x("bb_pend", 1, 0, 0, 3'd0, 7'h01); step();
      req1 = 7'h01;                 x("bb_valid", 1, 1, 0, 3'd1, 7'h01); step();
      if1.Irq_Done = 1'b1;          x("bb_done_req", 1, 1, 0, 3'd1, 7'h01); step();
      if1.Irq_Done = 1'b0; if1.Irq_Ack = 1'b1;
                                    x("bb_ack", 1, 0, 1, 3'd1, 7'h00); step();
      if1.Irq_Ack = 1'b0; if1.Irq_Done = 1'b1;
                                    x("bb_done", 1, 0, 0, 3'd0, 7'h00); step();
      if1.Irq_Done = 1'b0;
      en1 = 7'h7E; req1 = 7'h00;    x("en_pend", 1, 0, 0, 3'd0, 7'h01); step();
      req1 = 7'h01;                 x("en_masked_a", 1, 0, 0, 3'd0, 7'h01); step();
                                    x("en_masked_b", 1, 0, 0, 3'd0, 7'h01); step();
      en1 = 7'h7F;                  x("en_valid", 1, 1, 0, 3'd1, 7'h01); step();
      en1 = 7'h7E;                  x("en_withdraw", 1, 0, 0, 3'd0, 7'h01); step();
      en1 = 7'h7F;                  x("en_revalid", 1, 1, 0, 3'd1, 7'h01); step();
      if1.Irq_Ack = 1'b1;           x("en_ack", 1, 0, 1, 3'd1, 7'h00); step();
      if1.Irq_Ack = 1'b0; if1.Irq_Done = 1'b1;
                                    x("en_done", 1, 0, 0, 3'd0, 7'h00); step();
      if1.Irq_Done = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_source_dispatcher.md
# irq_source_dispatcher

Receiving end of the CPU's seven-line interrupt request bundle: where the request lines are otherwise OR-reduced to a single "any interrupt" flag, this block latches each source separately and applies per-source polarity and trigger type. It selects one source by fixed priority and hands its ID to the CPU interrupt logic over a valid/ack/done handshake. It sits between the peripheral request lines and the single-cycle CPU's trap/CSR stage.

## Interface
- BubblesMask, 7'h00, bit i = 1 inverts Req[i] before use (active-low source)
- EdgeMask, 7'h7F, bit i = 1 edge-triggered source, 0 level-triggered source
- Clock  in  1  single system clock; all state updates on its rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Req  in  7  raw request lines, synchronous to Clock; Req[0] = source 1
- Enable  in  7  per-source enable; a disabled source stays pending but is never selected
- Irq_Valid  out  1  dispatch request to CPU; high only in state REQ
- Irq_Id  out  3  selected source 1..7; 0 = none
- Irq_Ack  in  1  CPU accepts Irq_Id; meaningful only while Irq_Valid = 1
- Irq_Done  in  1  end-of-interrupt from CPU; meaningful only in state SERVICE
- Pending  out  7  registered pending bits (visible to CSR reads)
- Busy  out  1  high in state SERVICE

## Operation
- real_req = Req ^ BubblesMask. req_q is a register holding last cycle's real_req.
- Edge source i: pending[i] is set when real_req[i] & ~req_q[i]. It is cleared when Ack is accepted with Irq_Id = i+1. Set wins over a simultaneous clear. A second edge while the bit is already pending is merged.
- Level source i: pending[i] <= real_req[i] every cycle. Ack does not clear it; the handler must drop the source before Irq_Done.
- candidate = Pending & Enable. winner = lowest set index, so source 1 has the highest priority.
- FSM states, 2 bits:
  - IDLE: Valid = 0, Busy = 0. If candidate != 0, latch Irq_Id = winner + 1 and go to REQ.
  - REQ: Valid = 1 and Irq_Id is held stable, with no priority preemption.
    - Ack = 1: go to SERVICE.
    - Else, if the latched source is no longer a candidate (disabled, or a level source dropped): withdraw to IDLE, clear Irq_Id to 0, and leave Pending untouched.
    - Ack in the same cycle as a withdrawal condition: Ack wins.
  - SERVICE: Valid = 0, Busy = 1, Irq_Id is held. Irq_Done = 1 sends the FSM to IDLE and clears Irq_Id to 0. New requests keep latching into Pending.
- Ack outside REQ is ignored. Done outside SERVICE is ignored. Ack and Done together in REQ are treated as Ack only.
- No nesting: only one source is in service at a time.

## Timing
- Reset (asynchronous, immediate) clears state to IDLE, Pending = 0, req_q = 0, Irq_Valid = 0, Irq_Id = 0, Busy = 0.
  - Because req_q resets to 0, an edge source already asserted at reset release registers as an edge on the first clock.
- Latency: real_req rises before edge k, Pending is set after edge k, Irq_Valid is high after edge k+1. Request to Valid = 2 cycles.
- Ack sampled at edge m: Valid drops and Busy rises after edge m. The Pending clear for an edge source takes effect at edge m.
- Done sampled at edge d: IDLE after edge d. The next Valid comes no earlier than after edge d+1, giving at least one idle cycle.
- All outputs are registered. There are no combinational paths from any input to any output.

## Structure
- Shared package irq_pkg holds:
  - the state encoding: IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2
  - NUM_SRC = 7, ID_W = 3, ID_NONE = 3'd0
- Sub-module irq_prio_enc_7: combinational, 7-bit vector to 3-bit index+1 (lowest index first), 0 when the vector is empty.
- Expected size: about 200 lines of RTL.

## Test plan
- Reset: drive Reset_n low mid-SERVICE with Pending = 7'h05. Immediately: Valid = 0, Busy = 0, Id = 0, Pending = 0. Hold Req = 0 and release reset: FSM stays IDLE.
- Single edge: pulse Req[2] (source 3, edge type) for one cycle with Enable = 7'h7F.
  - Valid goes high 2 cycles later with Id = 3.
  - Ack: Pending[2] = 0, Busy = 1.
  - Done: IDLE, Id = 0.
- Priority: sources 5 and 2 rise together. Id = 2 first. After Done, Id = 5 follows with one idle cycle between.
- Withdrawal: level source 4 (EdgeMask = 7'h77) asserts, then drops while Valid = 1 and before Ack. Valid falls the next cycle, Id = 0, no SERVICE entered.
- Bubbles and Enable: BubblesMask = 7'h01 with Req[0] driven 1 then 0 gives Id = 1. With Enable[0] = 0 the source stays pending with Valid = 0; setting Enable[0] = 1 gives Valid 1 cycle later.
- Handshake corners:
  - Ack and Done together in REQ behave as Ack.
  - Ack in IDLE is ignored.
  - A new edge on the in-service source during the Ack cycle leaves Pending = 1.
